// File: rtl/reg_file_pkg.sv
// Shared sizing and index types for the architectural register file.
package reg_file_pkg;

    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned XLEN     = 32;

    typedef logic [REG_ID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]     word_t;

    localparam reg_id_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_qry.sv
// Combinational source-operand read port with forwarding of the same-cycle commit.
module reg_file_qry
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = 5
) (
    input  reg_id_t                               qry_id,
    input  word_t [REG_NUM-1:0]                   vals,
    input  logic  [REG_NUM-1:0]                   busys,
    input  logic  [REG_NUM-1:0][ROB_SIZE_BIT-1:0] deps,
    input  logic                                  is_update_val,
    input  reg_id_t                               update_val_id,
    input  logic  [ROB_SIZE_BIT-1:0]              update_val_dep,
    input  word_t                                 update_val,
    output logic                                  qry_busy,
    output logic  [ROB_SIZE_BIT-1:0]              qry_dep,
    output word_t                                 qry_val
);

    logic fwd_hit;

    // Forward only a commit that actually retires the current producer of this register.
    assign fwd_hit = is_update_val && (update_val_id == qry_id) && busys[qry_id]
                     && (deps[qry_id] == update_val_dep);

    always_comb begin
        qry_busy = busys[qry_id];
        qry_dep  = deps[qry_id];
        qry_val  = vals[qry_id];
        if (qry_id == REG_ZERO) begin
            qry_busy = 1'b0;
            qry_dep  = '0;
            qry_val  = '0;
        end else if (fwd_hit) begin
            qry_busy = 1'b0;
            qry_val  = update_val;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and ROB producer tag.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_BIT = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_clear,
    input  logic                    is_update_val,
    input  logic [4:0]              update_val_id,
    input  logic [ROB_SIZE_BIT-1:0] update_val_dep,
    input  logic [31:0]             update_val,
    input  logic                    is_update_dep,
    input  logic [4:0]              update_dep_id,
    input  logic [ROB_SIZE_BIT-1:0] update_dep,
    input  logic [4:0]              rf_qry1_id,
    output logic                    rf_qry1_busy,
    output logic [ROB_SIZE_BIT-1:0] rf_qry1_dep,
    output logic [31:0]             rf_qry1_val,
    input  logic [4:0]              rf_qry2_id,
    output logic                    rf_qry2_busy,
    output logic [ROB_SIZE_BIT-1:0] rf_qry2_dep,
    output logic [31:0]             rf_qry2_val
);

    word_t [REG_NUM-1:0]                   val_q;
    logic  [REG_NUM-1:0]                   busy_q;
    logic  [REG_NUM-1:0][ROB_SIZE_BIT-1:0] dep_q;

    logic commit_en;
    logic rename_en;

    assign commit_en = is_update_val && (update_val_id != REG_ZERO);
    assign rename_en = is_update_dep && (update_dep_id != REG_ZERO);

    // Later assignments override earlier ones: commit, then rename, then flush.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            val_q  <= '0;
            busy_q <= '0;
            dep_q  <= '0;
        end else if (rdy_in) begin
            if (commit_en) begin
                val_q[update_val_id] <= update_val;
                if (busy_q[update_val_id] && (dep_q[update_val_id] == update_val_dep)) begin
                    busy_q[update_val_id] <= 1'b0;
                end
            end
            if (rename_en) begin
                busy_q[update_dep_id] <= 1'b1;
                dep_q[update_dep_id]  <= update_dep;
            end
            if (rob_clear) begin
                busy_q <= '0;
                dep_q  <= '0;
            end
        end
    end

    reg_file_qry #(
        .ROB_SIZE_BIT (ROB_SIZE_BIT)
    ) u_qry1 (
        .qry_id         (rf_qry1_id),
        .vals           (val_q),
        .busys          (busy_q),
        .deps           (dep_q),
        .is_update_val  (is_update_val),
        .update_val_id  (update_val_id),
        .update_val_dep (update_val_dep),
        .update_val     (update_val),
        .qry_busy       (rf_qry1_busy),
        .qry_dep        (rf_qry1_dep),
        .qry_val        (rf_qry1_val)
    );

    reg_file_qry #(
        .ROB_SIZE_BIT (ROB_SIZE_BIT)
    ) u_qry2 (
        .qry_id         (rf_qry2_id),
        .vals           (val_q),
        .busys          (busy_q),
        .deps           (dep_q),
        .is_update_val  (is_update_val),
        .update_val_id  (update_val_id),
        .update_val_dep (update_val_dep),
        .update_val     (update_val),
        .qry_busy       (rf_qry2_busy),
        .qry_dep        (rf_qry2_dep),
        .qry_val        (rf_qry2_val)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file: one vector per clock cycle, outputs checked pre-edge.
module tb_reg_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        is_update_val;
    logic [4:0]  update_val_id;
    logic [4:0]  update_val_dep;
    logic [31:0] update_val;
    logic        is_update_dep;
    logic [4:0]  update_dep_id;
    logic [4:0]  update_dep;
    logic [4:0]  rf_qry1_id;
    logic        rf_qry1_busy;
    logic [4:0]  rf_qry1_dep;
    logic [31:0] rf_qry1_val;
    logic [4:0]  rf_qry2_id;
    logic        rf_qry2_busy;
    logic [4:0]  rf_qry2_dep;
    logic [31:0] rf_qry2_val;

    int tests  = 0;
    int failed = 0;

    reg_file #(
        .ROB_SIZE_BIT (5)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear      (rob_clear),
        .is_update_val  (is_update_val),
        .update_val_id  (update_val_id),
        .update_val_dep (update_val_dep),
        .update_val     (update_val),
        .is_update_dep  (is_update_dep),
        .update_dep_id  (update_dep_id),
        .update_dep     (update_dep),
        .rf_qry1_id     (rf_qry1_id),
        .rf_qry1_busy   (rf_qry1_busy),
        .rf_qry1_dep    (rf_qry1_dep),
        .rf_qry1_val    (rf_qry1_val),
        .rf_qry2_id     (rf_qry2_id),
        .rf_qry2_busy   (rf_qry2_busy),
        .rf_qry2_dep    (rf_qry2_dep),
        .rf_qry2_val    (rf_qry2_val)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        clr;
        logic        uv;
        logic [4:0]  uv_id;
        logic [4:0]  uv_dep;
        logic [31:0] uv_val;
        logic        ud;
        logic [4:0]  ud_id;
        logic [4:0]  ud_dep;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        eb1;
        logic [4:0]  ed1;
        logic [31:0] ev1;
        logic        eb2;
        logic [4:0]  ed2;
        logic [31:0] ev2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rdy, logic clr,
                                logic uv, logic [4:0] uv_id, logic [4:0] uv_dep,
                                logic [31:0] uv_val,
                                logic ud, logic [4:0] ud_id, logic [4:0] ud_dep,
                                logic [4:0] q1, logic eb1, logic [4:0] ed1, logic [31:0] ev1,
                                logic [4:0] q2, logic eb2, logic [4:0] ed2, logic [31:0] ev2);
        vec_t v;
        v.rdy = rdy; v.clr = clr;
        v.uv = uv; v.uv_id = uv_id; v.uv_dep = uv_dep; v.uv_val = uv_val;
        v.ud = ud; v.ud_id = ud_id; v.ud_dep = ud_dep;
        v.q1 = q1; v.eb1 = eb1; v.ed1 = ed1; v.ev1 = ev1;
        v.q2 = q2; v.eb2 = eb2; v.ed2 = ed2; v.ev2 = ev2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // dep is only meaningful while busy, or for x0 where it is pinned to zero.
    task automatic chk_port(input string tag, input logic [4:0] id,
                            input logic b, input logic [4:0] d, input logic [31:0] v,
                            input logic eb, input logic [4:0] ed, input logic [31:0] ev);
        chk({tag, " busy"}, {31'd0, b}, {31'd0, eb});
        chk({tag, " val"}, v, ev);
        if (eb || id == 5'd0) chk({tag, " dep"}, {27'd0, d}, {27'd0, ed});
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; rob_clear = 1'b0;
        is_update_val = 1'b0; update_val_id = '0; update_val_dep = '0; update_val = '0;
        is_update_dep = 1'b0; update_dep_id = '0; update_dep = '0;
    endtask

    initial begin
        rst_in = 1'b1;
        idle_inputs();
        rf_qry1_id = 5'd5;
        rf_qry2_id = 5'd5;

        //      rdy clr uv id   dep  val           ud id   dep   q1   b d    v            q2   b d    v
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  5,  0, 0, 32'h0,     5,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 0,  3,  0,  0, 0, 32'h0,     0,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  0,  0, 0, 32'h0,     0,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 5,  7,  5,  0, 0, 32'h0,     5,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  5,  1, 7, 32'h0,     5,  1, 7, 32'h0));
        vecs.push_back(mk(1, 0, 1, 5,  7, 32'h1234,  0, 0,  0,  5,  0, 0, 32'h1234,  5,  0, 0, 32'h1234));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  5,  0, 0, 32'h1234,  5,  0, 0, 32'h1234));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 6,  2,  6,  0, 0, 32'h0,     5,  0, 0, 32'h1234));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 6,  9,  6,  1, 2, 32'h0,     6,  1, 2, 32'h0));
        vecs.push_back(mk(1, 0, 1, 6,  2, 32'hAA,    0, 0,  0,  6,  1, 9, 32'h0,     6,  1, 9, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  6,  1, 9, 32'hAA,    6,  1, 9, 32'hAA));
        vecs.push_back(mk(1, 0, 1, 6,  9, 32'hBB,    0, 0,  0,  6,  0, 0, 32'hBB,    6,  0, 0, 32'hBB));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  6,  0, 0, 32'hBB,    6,  0, 0, 32'hBB));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 8,  4,  8,  0, 0, 32'h0,     8,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 1, 8,  4, 32'h55,    1, 8, 10,  8,  0, 0, 32'h55,    8,  0, 0, 32'h55));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  8,  1, 10, 32'h55,   8,  1, 10, 32'h55));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 1,  1,  1,  0, 0, 32'h0,     2,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 2,  2,  1,  1, 1, 32'h0,     2,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 3,  3,  2,  1, 2, 32'h0,     3,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     1, 4,  4,  3,  1, 3, 32'h0,     4,  0, 0, 32'h0));
        // Flush with a commit to x2 and a rename to x3 in the same cycle.
        vecs.push_back(mk(1, 1, 1, 2,  2, 32'h77,    1, 3, 12,  2,  0, 0, 32'h77,    4,  1, 4, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  2,  0, 0, 32'h77,    3,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  1,  0, 0, 32'h0,     4,  0, 0, 32'h0));
        // rdy low: rename and commit are dropped, queries still follow their ids.
        vecs.push_back(mk(0, 0, 0, 0,  0, 32'h0,     1, 9,  5,  9,  0, 0, 32'h0,     5,  0, 0, 32'h1234));
        vecs.push_back(mk(0, 0, 0, 0,  0, 32'h0,     1, 9,  5,  9,  0, 0, 32'h0,     6,  0, 0, 32'hBB));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  9,  0, 0, 32'h0,     8,  0, 0, 32'h55));
        vecs.push_back(mk(0, 0, 1, 7,  0, 32'h99,    0, 0,  0,  7,  0, 0, 32'h0,     7,  0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 32'h0,     0, 0,  0,  7,  0, 0, 32'h0,     7,  0, 0, 32'h0));

        // Reset state, checked while reset is still held.
        #12;
        chk_port("reset q1", 5'd0, rf_qry1_busy, rf_qry1_dep, rf_qry1_val, 1'b0, 5'd0, 32'h0);
        chk("reset q1 dep", {27'd0, rf_qry1_dep}, 32'd0);
        chk_port("reset q2", 5'd0, rf_qry2_busy, rf_qry2_dep, rf_qry2_val, 1'b0, 5'd0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_in);
            rdy_in         = vecs[i].rdy;
            rob_clear      = vecs[i].clr;
            is_update_val  = vecs[i].uv;
            update_val_id  = vecs[i].uv_id;
            update_val_dep = vecs[i].uv_dep;
            update_val     = vecs[i].uv_val;
            is_update_dep  = vecs[i].ud;
            update_dep_id  = vecs[i].ud_id;
            update_dep     = vecs[i].ud_dep;
            rf_qry1_id     = vecs[i].q1;
            rf_qry2_id     = vecs[i].q2;
            #1;
            chk_port($sformatf("v%0d q1", i), vecs[i].q1, rf_qry1_busy, rf_qry1_dep, rf_qry1_val,
                     vecs[i].eb1, vecs[i].ed1, vecs[i].ev1);
            chk_port($sformatf("v%0d q2", i), vecs[i].q2, rf_qry2_busy, rf_qry2_dep, rf_qry2_val,
                     vecs[i].eb2, vecs[i].ed2, vecs[i].ev2);
        end

        // Asynchronous reset in mid-cycle drops a live rename without a clock edge.
        @(negedge clk_in);
        idle_inputs();
        is_update_dep = 1'b1; update_dep_id = 5'd10; update_dep = 5'd6;
        rf_qry1_id = 5'd10; rf_qry2_id = 5'd5;
        @(negedge clk_in);
        idle_inputs();
        #1;
        chk_port("pre-rst x10", 5'd10, rf_qry1_busy, rf_qry1_dep, rf_qry1_val,
                 1'b1, 5'd6, 32'h0);
        #1;
        rst_in = 1'b1;
        #1;
        chk_port("async rst x10", 5'd10, rf_qry1_busy, rf_qry1_dep, rf_qry1_val,
                 1'b0, 5'd0, 32'h0);
        chk("async rst x10 dep", {27'd0, rf_qry1_dep}, 32'd0);
        chk_port("async rst x5", 5'd5, rf_qry2_busy, rf_qry2_dep, rf_qry2_val,
                 1'b0, 5'd0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
